// File: rtl/ddr4_sref_sequencer.sv
// Self-refresh sequencer for up to NUM_CH DDR4 controllers: masked entry
// (parallel or one channel at a time), acknowledge and calibration timeouts,
// and exit with optional calibration restore.
module ddr4_sref_sequencer #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned SEQ_ENTRY   = 0,
    parameter int unsigned RESTORE_CAL = 1,
    parameter int unsigned ACK_TIMEOUT = 65535,
    parameter int unsigned CAL_TIMEOUT = 4194303
) (
    input  logic              CLK_IN_250M,
    input  logic              sys_rst,
    input  logic              sref_enter_req,
    input  logic              sref_exit_req,
    input  logic              clear_err,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] app_sref_ack,
    input  logic [NUM_CH-1:0] init_calib_complete,
    output logic [NUM_CH-1:0] app_sref_req,
    output logic [NUM_CH-1:0] app_mem_init_skip,
    output logic [NUM_CH-1:0] app_xsdb_select,
    output logic [NUM_CH-1:0] app_restore_complete,
    output logic              busy,
    output logic              in_sref,
    output logic              done,
    output logic              err,
    output logic [NUM_CH-1:0] err_ch
);

    localparam int unsigned MAX_TO = (ACK_TIMEOUT > CAL_TIMEOUT) ? ACK_TIMEOUT : CAL_TIMEOUT;
    localparam int unsigned CNT_W  = $clog2(MAX_TO + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ENTER    = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_IN_SREF  = 3'd3;
    localparam logic [2:0] S_EXIT     = 3'd4;
    localparam logic [2:0] S_WAIT_CAL = 3'd5;
    localparam logic [2:0] S_RESTORE  = 3'd6;
    localparam logic [2:0] S_ERROR    = 3'd7;

    logic [2:0]        state, state_nxt;
    logic [NUM_CH-1:0] ack_meta, ack_s, cal_meta, cal_s;
    logic [NUM_CH-1:0] act_mask, act_mask_nxt;
    logic [NUM_CH-1:0] cur_bit, cur_bit_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [NUM_CH-1:0] unserviced, next_bit;
    logic [NUM_CH-1:0] req_nxt, skip_nxt, xsdb_nxt, rc_nxt, err_ch_nxt;
    logic              busy_nxt, in_sref_nxt, done_nxt, err_nxt;

    // One-hot of the lowest set bit (all zero when v is zero).
    function automatic logic [NUM_CH-1:0] lowest_bit(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] res;
        logic              found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (v[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    assign unserviced = act_mask & ~app_sref_req;
    assign next_bit   = lowest_bit(unserviced);

    // Two-flop synchronisers for the controller status inputs.
    always_ff @(posedge CLK_IN_250M or posedge sys_rst) begin
        if (sys_rst) begin
            ack_meta <= '0;
            ack_s    <= '0;
            cal_meta <= '0;
            cal_s    <= '0;
        end else begin
            ack_meta <= app_sref_ack;
            ack_s    <= ack_meta;
            cal_meta <= init_calib_complete;
            cal_s    <= cal_meta;
        end
    end

    // State register.
    always_ff @(posedge CLK_IN_250M or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, datapath and next output values. cur_bit is the channel set
    // being waited on: the whole mask in parallel mode, one bit in sequential
    // mode, so both modes share the WAIT_ACK completion test. restore_complete
    // and done are loaded on the way into RESTORE so they appear the cycle
    // after the final synchronised calib_complete.
    always_comb begin
        state_nxt    = state;
        act_mask_nxt = act_mask;
        cur_bit_nxt  = cur_bit;
        cnt_nxt      = cnt;
        req_nxt      = app_sref_req;
        skip_nxt     = app_mem_init_skip;
        xsdb_nxt     = app_xsdb_select;
        rc_nxt       = app_restore_complete;
        err_ch_nxt   = err_ch;
        done_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (sref_enter_req && (ch_mask != '0)) begin
                    act_mask_nxt = ch_mask;
                    skip_nxt     = '0;
                    xsdb_nxt     = '0;
                    rc_nxt       = '0;
                    state_nxt    = S_ENTER;
                end
            end
            S_ENTER: begin
                if (SEQ_ENTRY != 0) begin
                    cur_bit_nxt = next_bit;
                    req_nxt     = app_sref_req | next_bit;
                end else begin
                    cur_bit_nxt = act_mask;
                    req_nxt     = act_mask;
                end
                cnt_nxt   = CNT_W'(ACK_TIMEOUT);
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if ((ack_s & cur_bit) == cur_bit) begin
                    if (unserviced == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IN_SREF;
                    end else begin
                        state_nxt = S_ENTER;
                    end
                end else if (cnt == '0) begin
                    err_ch_nxt = app_sref_req & ~ack_s;
                    req_nxt    = '0;
                    state_nxt  = S_ERROR;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_IN_SREF: begin
                if (sref_exit_req) begin
                    state_nxt = S_EXIT;
                end
            end
            S_EXIT: begin
                req_nxt = app_sref_req & ~act_mask;
                if (RESTORE_CAL != 0) begin
                    skip_nxt = act_mask;
                    xsdb_nxt = act_mask;
                end
                cnt_nxt   = CNT_W'(CAL_TIMEOUT);
                state_nxt = S_WAIT_CAL;
            end
            S_WAIT_CAL: begin
                if ((cal_s & act_mask) == act_mask) begin
                    rc_nxt    = act_mask;
                    done_nxt  = 1'b1;
                    state_nxt = S_RESTORE;
                end else if (cnt == '0) begin
                    err_ch_nxt = act_mask & ~cal_s;
                    state_nxt  = S_ERROR;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RESTORE: begin
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (clear_err) begin
                    err_ch_nxt = '0;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_IN_SREF) && (state_nxt != S_ERROR);
        in_sref_nxt = (state_nxt == S_IN_SREF);
        err_nxt     = (state_nxt == S_ERROR);
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK_IN_250M or posedge sys_rst) begin
        if (sys_rst) begin
            act_mask             <= '0;
            cur_bit              <= '0;
            cnt                  <= '0;
            app_sref_req         <= '0;
            app_mem_init_skip    <= '0;
            app_xsdb_select      <= '0;
            app_restore_complete <= '0;
            err_ch               <= '0;
            busy                 <= 1'b0;
            in_sref              <= 1'b0;
            done                 <= 1'b0;
            err                  <= 1'b0;
        end else begin
            act_mask             <= act_mask_nxt;
            cur_bit              <= cur_bit_nxt;
            cnt                  <= cnt_nxt;
            app_sref_req         <= req_nxt;
            app_mem_init_skip    <= skip_nxt;
            app_xsdb_select      <= xsdb_nxt;
            app_restore_complete <= rc_nxt;
            err_ch               <= err_ch_nxt;
            busy                 <= busy_nxt;
            in_sref              <= in_sref_nxt;
            done                 <= done_nxt;
            err                  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ddr4_sref_sequencer.sv
// Bench for ddr4_sref_sequencer: a parallel/restore instance (dut_par) and a
// sequential/full-recalibration instance (dut_seq), each checked every cycle
// against a timeline computed from the entry/exit latency and timeout rules.
module tb_ddr4_sref_sequencer;

    localparam int ACK_TO = 20;
    localparam int CAL_TO = 60;
    localparam int BIG    = 100000;
    localparam int MAXT   = 128;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] skip;
        logic [2:0] xsdb;
        logic [2:0] rc;
        logic [2:0] errch;
        logic       busy;
        logic       insref;
        logic       done;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst      [2];
    logic       en_req   [2];
    logic       ex_req   [2];
    logic       clr_req  [2];
    logic [2:0] ch_mask  [2];
    logic [2:0] ack      [2];
    logic [2:0] cal      [2];
    logic [2:0] req      [2];
    logic [2:0] skip     [2];
    logic [2:0] xsdb     [2];
    logic [2:0] rc       [2];
    logic [2:0] errch    [2];
    logic       busy     [2];
    logic       insref   [2];
    logic       done     [2];
    logic       err      [2];

    logic [2:0] lvl_skip [2];
    logic [2:0] lvl_rc   [2];

    int vectors     = 0;
    int miscompares = 0;
    int cur_idx     = 0;

    always #5 clk = ~clk;

    ddr4_sref_sequencer #(
        .NUM_CH(3), .SEQ_ENTRY(0), .RESTORE_CAL(1), .ACK_TIMEOUT(ACK_TO), .CAL_TIMEOUT(CAL_TO)
    ) dut_par (
        .CLK_IN_250M(clk), .sys_rst(rst[0]),
        .sref_enter_req(en_req[0]), .sref_exit_req(ex_req[0]), .clear_err(clr_req[0]),
        .ch_mask(ch_mask[0]), .app_sref_ack(ack[0]), .init_calib_complete(cal[0]),
        .app_sref_req(req[0]), .app_mem_init_skip(skip[0]), .app_xsdb_select(xsdb[0]),
        .app_restore_complete(rc[0]), .busy(busy[0]), .in_sref(insref[0]),
        .done(done[0]), .err(err[0]), .err_ch(errch[0])
    );

    ddr4_sref_sequencer #(
        .NUM_CH(3), .SEQ_ENTRY(1), .RESTORE_CAL(0), .ACK_TIMEOUT(ACK_TO), .CAL_TIMEOUT(CAL_TO)
    ) dut_seq (
        .CLK_IN_250M(clk), .sys_rst(rst[1]),
        .sref_enter_req(en_req[1]), .sref_exit_req(ex_req[1]), .clear_err(clr_req[1]),
        .ch_mask(ch_mask[1]), .app_sref_ack(ack[1]), .init_calib_complete(cal[1]),
        .app_sref_req(req[1]), .app_mem_init_skip(skip[1]), .app_xsdb_select(xsdb[1]),
        .app_restore_complete(rc[1]), .busy(busy[1]), .in_sref(insref[1]),
        .done(done[1]), .err(err[1]), .err_ch(errch[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [7:0] o, input logic [7:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s dut%0d t=%0d: observed %0h expected %0h", tag, cur_idx, t, o, e);
        end
    endtask

    task automatic check_cycle(input int idx, input int t, input exp_t e);
        chk("sref_req",         t, 8'(req[idx]),    8'(e.req));
        chk("mem_init_skip",    t, 8'(skip[idx]),   8'(e.skip));
        chk("xsdb_select",      t, 8'(xsdb[idx]),   8'(e.xsdb));
        chk("restore_complete", t, 8'(rc[idx]),     8'(e.rc));
        chk("err_ch",           t, 8'(errch[idx]),  8'(e.errch));
        chk("busy",             t, 8'(busy[idx]),   8'(e.busy));
        chk("in_sref",          t, 8'(insref[idx]), 8'(e.insref));
        chk("done",             t, 8'(done[idx]),   8'(e.done));
        chk("err",              t, 8'(err[idx]),    8'(e.err));
    endtask

    function automatic exp_t idle_exp(input int idx);
        exp_t e;
        e      = '0;
        e.skip = lvl_skip[idx];
        e.xsdb = lvl_skip[idx];
        e.rc   = lvl_rc[idx];
        return e;
    endfunction

    // Entry from IDLE; delay <0 means the channel never acknowledges.
    task automatic run_entry(input int idx, input logic [2:0] mask,
                             input int d0, input int d1, input int d2,
                             output logic ok, output logic [2:0] ec);
        int   dly[3];
        int   ack_at[3];
        int   req_at[3];
        int   r, cut, tend, terr, tstop;
        logic nz;
        logic [2:0] junk;
        exp_t e;
        exp_t tl[MAXT];
        cur_idx = idx;
        dly = '{d0, d1, d2};
        ack[idx] = '0;
        cal[idx] = cal[idx] & ~mask;
        for (int k = 0; k < 3; k++) begin
            step();
            check_cycle(idx, -1, idle_exp(idx));
        end
        ok = 1'b1; ec = '0; tend = 0; terr = BIG;
        for (int i = 0; i < 3; i++) begin
            ack_at[i] = BIG;
            req_at[i] = BIG;
        end
        if (idx == 0) begin
            cut = 2 + ACK_TO;
            for (int i = 0; i < 3; i++) begin
                if (mask[i]) begin
                    req_at[i] = 2;
                    if (dly[i] >= 0) ack_at[i] = 2 + dly[i];
                    if (ack_at[i] + 2 > cut) begin
                        ok = 1'b0;
                        ec[i] = 1'b1;
                    end else if (ack_at[i] + 3 > tend) begin
                        tend = ack_at[i] + 3;
                    end
                end
            end
            if (!ok) terr = cut + 1;
        end else begin
            r = 2;
            for (int i = 0; i < 3; i++) begin
                if (mask[i] && ok) begin
                    req_at[i] = r;
                    cut = r + ACK_TO;
                    if (dly[i] >= 0) ack_at[i] = r + dly[i];
                    if (ack_at[i] + 2 > cut) begin
                        ok = 1'b0;
                        ec[i] = 1'b1;
                        terr = cut + 1;
                    end else begin
                        tend = ack_at[i] + 3;
                        r = ack_at[i] + 4;
                    end
                end
            end
        end
        tstop = ok ? tend : terr;
        for (int t = 1; t <= tstop + 2; t++) begin
            e = '0;
            for (int i = 0; i < 3; i++) if (req_at[i] <= t && t < terr) e.req[i] = 1'b1;
            e.busy   = (t < tstop);
            e.insref = ok && (t >= tend);
            e.done   = ok && (t == tend);
            e.err    = !ok && (t >= terr);
            e.errch  = (!ok && t >= terr) ? ec : 3'b000;
            tl[t] = e;
        end
        lvl_skip[idx] = '0;
        lvl_rc[idx]   = '0;
        junk = 3'($urandom);
        for (int t = 0; t <= tstop + 2; t++) begin
            if (t > 0) begin
                step();
                check_cycle(idx, t, tl[t]);
            end
            nz = (t > 0) && (t < tstop);
            en_req[idx]  = (t == 0) ? 1'b1 : (nz && $urandom_range(0, 5) == 0);
            ch_mask[idx] = (t == 0) ? mask : 3'($urandom);
            ex_req[idx]  = (t == 0) ? 1'($urandom_range(0, 1)) : (nz && $urandom_range(0, 5) == 0);
            clr_req[idx] = (t == 0 || nz) && $urandom_range(0, 5) == 0;
            for (int i = 0; i < 3; i++) ack[idx][i] = mask[i] ? (t >= ack_at[i]) : junk[i];
        end
    endtask

    // Exit from IN_SREF; delay <0 means the channel never calibrates.
    task automatic run_exit(input int idx, input logic [2:0] mask,
                            input int g0, input int g1, input int g2, input logic both,
                            output logic ok, output logic [2:0] ec);
        int   g[3];
        int   cal_at[3];
        int   cut, tend, terr, tstop;
        logic nz;
        logic [2:0] junk, skipv;
        exp_t e;
        exp_t tl[MAXT];
        cur_idx = idx;
        g = '{g0, g1, g2};
        cut = 2 + CAL_TO;
        ok = 1'b1; ec = '0; tend = 0;
        skipv = (idx == 0) ? mask : 3'b000;
        for (int i = 0; i < 3; i++) begin
            cal_at[i] = BIG;
            if (mask[i]) begin
                if (g[i] >= 0) cal_at[i] = 2 + g[i];
                if (cal_at[i] + 2 > cut) begin
                    ok = 1'b0;
                    ec[i] = 1'b1;
                end else if (cal_at[i] + 3 > tend) begin
                    tend = cal_at[i] + 3;
                end
            end
        end
        terr  = ok ? BIG : cut + 1;
        tstop = ok ? tend + 1 : terr;
        for (int t = 1; t <= tstop + 2; t++) begin
            e = '0;
            e.req    = (t == 1) ? mask : 3'b000;
            e.skip   = (t >= 2) ? skipv : 3'b000;
            e.xsdb   = (t >= 2) ? skipv : 3'b000;
            e.rc     = (ok && t >= tend) ? mask : 3'b000;
            e.busy   = (t < tstop);
            e.done   = ok && (t == tend);
            e.err    = !ok && (t >= terr);
            e.errch  = (!ok && t >= terr) ? ec : 3'b000;
            tl[t] = e;
        end
        junk = 3'($urandom);
        for (int t = 0; t <= tstop + 2; t++) begin
            if (t > 0) begin
                step();
                check_cycle(idx, t, tl[t]);
            end
            nz = (t > 0) && (t < tstop);
            ex_req[idx]  = (t == 0) ? 1'b1 : (nz && $urandom_range(0, 5) == 0);
            en_req[idx]  = (t == 0) ? both : (nz && $urandom_range(0, 5) == 0);
            ch_mask[idx] = (t == 0) ? 3'($urandom_range(1, 7)) : 3'($urandom);
            clr_req[idx] = (t == 0 || nz) && $urandom_range(0, 5) == 0;
            for (int i = 0; i < 3; i++) cal[idx][i] = mask[i] ? (t >= cal_at[i]) : junk[i];
        end
        lvl_skip[idx] = skipv;
        lvl_rc[idx]   = ok ? mask : 3'b000;
    endtask

    // In ERROR: enter/exit are ignored, clear_err returns to IDLE.
    task automatic clear_error(input int idx, input logic [2:0] ec);
        exp_t e;
        cur_idx = idx;
        en_req[idx] = 1'b1; ch_mask[idx] = 3'b111; ex_req[idx] = 1'b1;
        step();
        en_req[idx] = 1'b0; ex_req[idx] = 1'b0;
        e = idle_exp(idx);
        e.err = 1'b1;
        e.errch = ec;
        check_cycle(idx, 1, e);
        clr_req[idx] = 1'b1;
        step();
        clr_req[idx] = 1'b0;
        check_cycle(idx, 2, idle_exp(idx));
    endtask

    // Empty-mask enter, exit and clear in IDLE are all no-ops.
    task automatic idle_pokes(input int idx);
        cur_idx = idx;
        en_req[idx] = 1'b1; ch_mask[idx] = 3'b000;
        step();
        en_req[idx] = 1'b0;
        check_cycle(idx, 1, idle_exp(idx));
        ex_req[idx] = 1'b1;
        step();
        ex_req[idx] = 1'b0;
        check_cycle(idx, 2, idle_exp(idx));
        clr_req[idx] = 1'b1;
        step();
        clr_req[idx] = 1'b0;
        check_cycle(idx, 3, idle_exp(idx));
        step();
        check_cycle(idx, 4, idle_exp(idx));
    endtask

    // Asynchronous reset while waiting for acknowledge.
    task automatic reset_mid(input int idx);
        exp_t e;
        cur_idx = idx;
        ack[idx] = '0;
        en_req[idx] = 1'b1; ch_mask[idx] = 3'b111;
        step();
        en_req[idx] = 1'b0;
        step();
        step();
        e = '0;
        e.req  = (idx == 0) ? 3'b111 : 3'b001;
        e.busy = 1'b1;
        check_cycle(idx, 3, e);
        #3;
        rst[idx] = 1'b1;
        #1;
        lvl_skip[idx] = '0;
        lvl_rc[idx]   = '0;
        check_cycle(idx, 100, '0);
        step();
        check_cycle(idx, 101, '0);
        #4;
        rst[idx] = 1'b0;
        step();
        check_cycle(idx, 102, idle_exp(idx));
        step();
        check_cycle(idx, 103, idle_exp(idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [2:0] ec;
        logic [2:0] m;
        int         d[3];
        int         g[3];

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; en_req[i] = 1'b0; ex_req[i] = 1'b0; clr_req[i] = 1'b0;
            ch_mask[i] = '0; ack[i] = '0; cal[i] = '0;
            lvl_skip[i] = '0; lvl_rc[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            cur_idx = i;
            check_cycle(i, 0, '0);
        end
        #4;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        // Parallel entry with mask 101, acks after 10 cycles, calib after ~50.
        idle_pokes(0);
        run_entry(0, 3'b101, 10, -1, 10, ok, ec);
        run_exit(0, 3'b101, 48, 0, 48, 1'b0, ok, ec);
        idle_pokes(0);

        // Sequential entry over all three channels, full-recal exit with a
        // simultaneous enter pulse.
        run_entry(1, 3'b111, 3, 5, 2, ok, ec);
        run_exit(1, 3'b111, 10, 20, 30, 1'b1, ok, ec);
        idle_pokes(1);

        // Acknowledge timeouts with ch1 silent.
        run_entry(0, 3'b111, 3, -1, 5, ok, ec);
        clear_error(0, ec);
        run_entry(1, 3'b111, 2, -1, 3, ok, ec);
        clear_error(1, ec);

        // Acknowledge seen exactly at expiry wins; one cycle later loses.
        run_entry(0, 3'b011, 18, 0, 0, ok, ec);
        run_exit(0, 3'b011, 58, 5, 0, 1'b1, ok, ec);
        run_entry(0, 3'b001, 19, 0, 0, ok, ec);
        clear_error(0, ec);
        run_entry(1, 3'b110, 0, 18, 18, ok, ec);
        run_exit(1, 3'b110, 0, 59, 3, 1'b0, ok, ec);
        clear_error(1, ec);

        // Calibration timeout with a silent channel.
        run_entry(0, 3'b110, 0, 1, 2, ok, ec);
        run_exit(0, 3'b110, 0, 4, -1, 1'b0, ok, ec);
        clear_error(0, ec);

        // Randomised operations on both instances.
        for (int idx = 0; idx < 2; idx++) begin
            for (int n = 0; n < 12; n++) begin
                m = 3'($urandom_range(1, 7));
                for (int i = 0; i < 3; i++) begin
                    d[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
                    g[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
                end
                run_entry(idx, m, d[0], d[1], d[2], ok, ec);
                if (!ok) begin
                    clear_error(idx, ec);
                end else begin
                    run_exit(idx, m, g[0], g[1], g[2], 1'($urandom_range(0, 1)), ok, ec);
                    if (!ok) clear_error(idx, ec);
                end
            end
        end

        // Reset during WAIT_ACK, then a clean operation afterwards.
        for (int idx = 0; idx < 2; idx++) begin
            reset_mid(idx);
            run_entry(idx, 3'b100, 1, 1, 1, ok, ec);
            run_exit(idx, 3'b100, 2, 2, 2, 1'b0, ok, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
